// File: rtl/bounded_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bounded_counter_monitor
// Brief    : Enable counter (wrap/saturate) with bounded-count checker,
//            sticky fail flag, saturating violation counter and monitor FSM.
// Revision : 1.0 - initial release
// ============================================================================
module bounded_counter_monitor #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 5,
  parameter int HIST  = 1,
  parameter int MODE  = 0,
  parameter int FCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             wrap,
  output logic             fail,
  output logic [FCW-1:0]   fail_cnt,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] C_MAXV  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   C_LIMIT = (WIDTH+1)'(LIMIT);
  localparam logic [FCW-1:0]   C_FMAX  = {FCW{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_fail;
  logic [FCW-1:0]   r_fail_cnt;
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [HIST-1:0]  r_hist;
  logic             w_hist_in;
  logic             w_ena_dly;
  logic             w_at_max;
  logic             w_below;
  logic             w_viol;

  assign w_at_max  = (r_count == C_MAXV);
  assign w_hist_in = ena & ~clr;
  assign w_ena_dly = r_hist[HIST-1];
  // Widened compare keeps LIMIT == 2**WIDTH from ever flagging
  assign w_below   = ({1'b0, r_count} < C_LIMIT);
  assign w_viol    = w_ena_dly & ~w_below;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= ena & ~clr & w_at_max;
      if (clr) begin
        r_count <= '0;
      end else if (ena) begin
        if (!w_at_max) begin
          r_count <= r_count + 1'b1;
        end else if (MODE == 0) begin
          r_count <= '0;
        end
      end
    end
  end

  generate
    if (HIST == 1) begin : g_hist_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hist <= '0;
        else     r_hist <= w_hist_in;
      end
    end else begin : g_hist_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hist <= '0;
        else     r_hist <= {r_hist[HIST-2:0], w_hist_in};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
    end else if (clr) begin
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
    end else if (w_viol) begin
      r_fail <= 1'b1;
      if (r_fail_cnt != C_FMAX) r_fail_cnt <= r_fail_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = S_IDLE;
    end else if (w_viol) begin
      w_next_state = S_FAIL;
    end else begin
      case (r_state)
        S_IDLE:  if (ena) w_next_state = S_RUN;
        S_RUN:   w_next_state = S_RUN;
        S_FAIL:  w_next_state = S_FAIL;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state    = r_state;
    count    = r_count;
    wrap     = r_wrap;
    fail     = r_fail;
    fail_cnt = r_fail_cnt;
    valid    = w_ena_dly & w_below;
  end

endmodule
`default_nettype wire

// File: tb/tb_bounded_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounded_counter_monitor
// Brief    : Directed self-checking bench for bounded_counter_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounded_counter_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ena0 = 0, clr0 = 0, ena1 = 0, clr1 = 0;
  logic       ena2 = 0, clr2 = 0, ena3 = 0, clr3 = 0;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic       val0, val1, val2, val3;
  logic       wrp0, wrp1, wrp2, wrp3;
  logic       fl0, fl1, fl2, fl3;
  logic [7:0] fc0, fc1, fc2, fc3;
  logic [1:0] st0, st1, st2, st3;

  int n_cmp = 0;
  int n_err = 0;

  bounded_counter_monitor #(.WIDTH(4), .LIMIT(5), .HIST(1), .MODE(0), .FCW(8)) u0 (
    .clk(clk), .rst(rst), .ena(ena0), .clr(clr0), .count(cnt0), .valid(val0),
    .wrap(wrp0), .fail(fl0), .fail_cnt(fc0), .state(st0));
  bounded_counter_monitor #(.WIDTH(4), .LIMIT(16), .HIST(1), .MODE(0), .FCW(8)) u1 (
    .clk(clk), .rst(rst), .ena(ena1), .clr(clr1), .count(cnt1), .valid(val1),
    .wrap(wrp1), .fail(fl1), .fail_cnt(fc1), .state(st1));
  bounded_counter_monitor #(.WIDTH(4), .LIMIT(16), .HIST(1), .MODE(1), .FCW(8)) u2 (
    .clk(clk), .rst(rst), .ena(ena2), .clr(clr2), .count(cnt2), .valid(val2),
    .wrap(wrp2), .fail(fl2), .fail_cnt(fc2), .state(st2));
  bounded_counter_monitor #(.WIDTH(4), .LIMIT(5), .HIST(3), .MODE(0), .FCW(8)) u3 (
    .clk(clk), .rst(rst), .ena(ena3), .clr(clr3), .count(cnt3), .valid(val3),
    .wrap(wrp3), .fail(fl3), .fail_cnt(fc3), .state(st3));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    rst = 1'b0;

    // reset state
    check("rst_count", int'(cnt0), 0);
    check("rst_valid", int'(val0), 0);
    check("rst_wrap",  int'(wrp0), 0);
    check("rst_fail",  int'(fl0), 0);
    check("rst_fcnt",  int'(fc0), 0);
    check("rst_state", int'(st0), 0);

    // defaults: count 1..4 valid, 5 invalid, fail one edge later
    ena0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t1_count", int'(cnt0), i);
      check("t1_valid", int'(val0), 1);
    end
    check("t1_state_run", int'(st0), 1);
    step();
    check("t1_count5", int'(cnt0), 5);
    check("t1_valid5", int'(val0), 0);
    check("t1_fail_pre", int'(fl0), 0);
    step();
    check("t1_fail", int'(fl0), 1);
    check("t1_state_fail", int'(st0), 2);
    check("t1_fcnt", int'(fc0), 1);
    step();
    check("t4_count7", int'(cnt0), 7);
    check("t4_fcnt2", int'(fc0), 2);

    // clr + ena together while failing
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    check("t4_count", int'(cnt0), 0);
    check("t4_fail",  int'(fl0), 0);
    check("t4_fcnt",  int'(fc0), 0);
    check("t4_state", int'(st0), 0);
    check("t4_valid", int'(val0), 0);

    // async reset mid-count
    repeat (9) step();
    check("t6_count9", int'(cnt0), 9);
    check("t6_fail_pre", int'(fl0), 1);
    rst = 1'b1;
    #2;
    check("t6_count", int'(cnt0), 0);
    check("t6_fail",  int'(fl0), 0);
    check("t6_state", int'(st0), 0);
    check("t6_fcnt",  int'(fc0), 0);
    rst = 1'b0;
    step();
    check("t6_after_count", int'(cnt0), 1);
    check("t6_after_state", int'(st0), 1);
    ena0 = 1'b0;

    // wrap mode, LIMIT=16
    ena1 = 1'b1;
    repeat (15) step();
    check("t2_count15", int'(cnt1), 15);
    check("t2_wrap_pre", int'(wrp1), 0);
    check("t2_valid15", int'(val1), 1);
    step();
    check("t2_count0", int'(cnt1), 0);
    check("t2_wrap", int'(wrp1), 1);
    step();
    check("t2_count1", int'(cnt1), 1);
    check("t2_wrap_off", int'(wrp1), 0);
    check("t2_fail", int'(fl1), 0);
    ena1 = 1'b0;

    // saturate mode, LIMIT=16
    ena2 = 1'b1;
    repeat (15) step();
    check("t3_count15", int'(cnt2), 15);
    check("t3_wrap_pre", int'(wrp2), 0);
    step();
    check("t3_hold_a", int'(cnt2), 15);
    check("t3_wrap_a", int'(wrp2), 1);
    step();
    check("t3_hold_b", int'(cnt2), 15);
    check("t3_wrap_b", int'(wrp2), 1);
    ena2 = 1'b0;
    step();
    check("t3_hold_c", int'(cnt2), 15);
    check("t3_wrap_c", int'(wrp2), 0);
    check("t3_fail", int'(fl2), 0);

    // HIST=3 single pulse
    check("t5_valid_pre", int'(val3), 0);
    ena3 = 1'b1;
    step();
    ena3 = 1'b0;
    check("t5_count", int'(cnt3), 1);
    check("t5_valid_t1", int'(val3), 0);
    step();
    check("t5_valid_t2", int'(val3), 0);
    step();
    check("t5_valid_t3", int'(val3), 1);
    check("t5_count_t3", int'(cnt3), 1);
    step();
    check("t5_valid_t4", int'(val3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
